rs_ff_nor: RTL and testbench



---
 rtl/rs_ff_pkg.sv | 23 ++
 rtl/rs_ff_nor_bit.sv | 54 +++++
 rtl/rs_ff_nor.sv | 31 +++
 tb/tb_rs_ff_nor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rs_ff_pkg.sv
// Shared state encoding and next-state decode for the clocked NOR-style RS flip-flop.
package rs_ff_pkg;

  typedef enum logic [1:0] {
    RS_RESET  = 2'b00,
    RS_SET    = 2'b01,
    RS_FORBID = 2'b10
  } rs_state_e;

  // A hold out of FORBID resolves to RESET so the slice never keeps an ambiguous state.
  function automatic rs_state_e rs_next_state(input logic s, input logic r,
                                              input rs_state_e cur);
    rs_state_e nxt;
    case ({s, r})
      2'b10:   nxt = RS_SET;
      2'b01:   nxt = RS_RESET;
      2'b11:   nxt = RS_FORBID;
      default: nxt = (cur == RS_SET) ? RS_SET : RS_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rs_ff_nor_bit.sv
// Single RS bit-slice: state register plus decode of Q, Qbar and invalid from that state.
module rs_ff_nor_bit
  import rs_ff_pkg::*;
#(
  parameter logic FORBID_Q = 1'b0
) (
  input  logic clk,
  input  logic clear,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qbar,
  output logic invalid
);

  rs_state_e state_q;
  rs_state_e state_d;

  always_comb begin
    state_d = rs_next_state(S, R, state_q);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= RS_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend only on the registered state, so there is no path from S, R or clear.
  always_comb begin
    Q       = 1'b0;
    Qbar    = 1'b1;
    invalid = 1'b0;
    case (state_q)
      RS_SET: begin
        Q    = 1'b1;
        Qbar = 1'b0;
      end
      RS_FORBID: begin
        Q       = FORBID_Q;
        Qbar    = FORBID_Q;
        invalid = 1'b1;
      end
      default: begin
        Q       = 1'b0;
        Qbar    = 1'b1;
        invalid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rs_ff_nor.sv
// WIDTH independent clocked RS slices sharing one clock and one synchronous clear.
module rs_ff_nor
  import rs_ff_pkg::*;
#(
  parameter int   WIDTH    = 1,
  parameter logic FORBID_Q = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] invalid
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    rs_ff_nor_bit #(
      .FORBID_Q(FORBID_Q)
    ) u_bit (
      .clk    (clk),
      .clear  (clear),
      .S      (S[i]),
      .R      (R[i]),
      .Q      (Q[i]),
      .Qbar   (Qbar[i]),
      .invalid(invalid[i])
    );
  end

endmodule

// File: tb/tb_rs_ff_nor.sv
// Directed self-checking bench for rs_ff_nor with four slices and a truth-table model for the sweep.
module tb_rs_ff_nor;

  localparam int W = 4;

  logic         clk;
  logic         clear;
  logic [W-1:0] S;
  logic [W-1:0] R;
  logic [W-1:0] Q;
  logic [W-1:0] Qbar;
  logic [W-1:0] invalid;

  int n_total;
  int n_bad;

  rs_ff_nor #(
    .WIDTH   (W),
    .FORBID_Q(1'b0)
  ) dut (
    .clk    (clk),
    .clear  (clear),
    .S      (S),
    .R      (R),
    .Q      (Q),
    .Qbar   (Qbar),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance past one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; S = 4'hF; R = 4'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({Q, Qbar, invalid} !== {4'h0, 4'hF, 4'h0}) begin
        n_bad++;
        $display("[TB] FAIL reset_edge%0d Q/Qbar/inv got %h/%h/%h want 0/f/0", i, Q, Qbar, invalid);
      end
    end
  endtask

  task automatic test_set_hold_reset();
    clear = 1'b0; S = 4'hF; R = 4'h0;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'hF, 4'h0, 4'h0}) begin
      n_bad++;
      $display("[TB] FAIL set Q/Qbar/inv got %h/%h/%h want f/0/0", Q, Qbar, invalid);
    end
    S = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({Q, Qbar, invalid} !== {4'hF, 4'h0, 4'h0}) begin
        n_bad++;
        $display("[TB] FAIL hold%0d Q/Qbar/inv got %h/%h/%h want f/0/0", i, Q, Qbar, invalid);
      end
    end
    R = 4'hF;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'h0, 4'hF, 4'h0}) begin
      n_bad++;
      $display("[TB] FAIL reset_input Q/Qbar/inv got %h/%h/%h want 0/f/0", Q, Qbar, invalid);
    end
  endtask

  task automatic test_forbidden();
    S = 4'hF; R = 4'hF;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'h0, 4'h0, 4'hF}) begin
      n_bad++;
      $display("[TB] FAIL forbid_enter Q/Qbar/inv got %h/%h/%h want 0/0/f", Q, Qbar, invalid);
    end
    S = 4'h0; R = 4'h0;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'h0, 4'hF, 4'h0}) begin
      n_bad++;
      $display("[TB] FAIL forbid_exit_hold Q/Qbar/inv got %h/%h/%h want 0/f/0", Q, Qbar, invalid);
    end
    S = 4'hF; R = 4'hF;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'h0, 4'h0, 4'hF}) begin
      n_bad++;
      $display("[TB] FAIL forbid_reenter Q/Qbar/inv got %h/%h/%h want 0/0/f", Q, Qbar, invalid);
    end
    R = 4'h0;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'hF, 4'h0, 4'h0}) begin
      n_bad++;
      $display("[TB] FAIL forbid_exit_set Q/Qbar/inv got %h/%h/%h want f/0/0", Q, Qbar, invalid);
    end
  endtask

  task automatic test_glitch();
    S = 4'h0; R = 4'hF;
    tick();
    R = 4'h0;
    #3 S = 4'hF;
    #2;
    n_total++;
    if ({Q, Qbar, invalid} !== {4'h0, 4'hF, 4'h0}) begin
      n_bad++;
      $display("[TB] FAIL glitch_mid Q/Qbar/inv got %h/%h/%h want 0/f/0", Q, Qbar, invalid);
    end
    #2 S = 4'h0;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'h0, 4'hF, 4'h0}) begin
      n_bad++;
      $display("[TB] FAIL glitch_edge Q/Qbar/inv got %h/%h/%h want 0/f/0", Q, Qbar, invalid);
    end
  endtask

  // Slice 0 forbidden, slice 1 reset, slice 2 set, slice 3 holds its cleared state.
  task automatic test_slices();
    clear = 1'b1; S = 4'h0; R = 4'h0;
    tick();
    clear = 1'b0; S = 4'b0101; R = 4'b0011;
    tick();
    n_total++;
    if ({Q, Qbar, invalid} !== {4'b0100, 4'b1010, 4'b0001}) begin
      n_bad++;
      $display("[TB] FAIL slices Q/Qbar/inv got %b/%b/%b want 0100/1010/0001", Q, Qbar, invalid);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] mq, mb, mi;
    logic [W-1:0] s_now, r_now;
    logic         c_now;
    mq = '0; mb = '1; mi = '0;
    for (int k = 0; k < 100; k++) begin
      c_now = ~k[2];
      s_now = {W{k[1]}} ^ 4'b0110;
      r_now = {W{k[0]}} ^ 4'b0011;
      clear = c_now; S = s_now; R = r_now;
      tick();
      for (int b = 0; b < W; b++) begin
        if (c_now) begin
          mq[b] = 1'b0; mb[b] = 1'b1; mi[b] = 1'b0;
        end else begin
          case ({s_now[b], r_now[b]})
            2'b10: begin mq[b] = 1'b1; mb[b] = 1'b0; mi[b] = 1'b0; end
            2'b01: begin mq[b] = 1'b0; mb[b] = 1'b1; mi[b] = 1'b0; end
            2'b11: begin mq[b] = 1'b0; mb[b] = 1'b0; mi[b] = 1'b1; end
            default: begin
              if (mi[b]) begin
                mq[b] = 1'b0; mb[b] = 1'b1; mi[b] = 1'b0;
              end
            end
          endcase
        end
      end
      n_total++;
      if ({Q, Qbar, invalid} !== {mq, mb, mi}) begin
        n_bad++;
        $display("[TB] FAIL sweep_step%0d Q/Qbar/inv got %b/%b/%b want %b/%b/%b",
                 k, Q, Qbar, invalid, mq, mb, mi);
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear   = 1'b1;
    S       = '0;
    R       = '0;
    #1;
    test_reset();
    test_set_hold_reset();
    test_forbidden();
    test_glitch();
    test_slices();
    test_sweep();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
